lfsr_interval_timer: RTL and testbench

Parametrised LFSR-based interval timer, successor to the fixed 100 ms timer. A configurable-width XNOR LFSR generates a base tick. A tick counter counts a run-time programmable number of ticks and then raises timeout. Supports one-shot and periodic modes, pause via enable, abort, retrigger, and a zero-interval error. Used by pattern-matching control FSMs for display/entry timeouts.

---
 rtl/lfsr_interval_timer.sv | 140 ++++++++++++++
 tb/tb_lfsr_interval_timer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_interval_timer.sv
// lfsr_interval_timer: programmable interval timer built on an XNOR LFSR base tick.
// The LFSR runs from 0 up to TICK_END, which marks one base tick. A tick counter
// then counts up to the programmed interval and raises a timeout, either once or
// periodically.
// Optional build macro: TIMER_STICKY_IRQ_EN adds the irq_clr input and the sticky
// irq output.
module lfsr_interval_timer #(
  parameter int                LFSR_W   = 16,
  parameter logic [LFSR_W-1:0] TAPS     = 16'h8016,
  parameter logic [LFSR_W-1:0] TICK_END = 16'hBD31,
  parameter int                CNT_W    = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             start,
  input  logic             abort,
  input  logic             periodic,
  input  logic [CNT_W-1:0] interval,
  output logic             busy,
  output logic             tick,
  output logic             timeout,
  output logic             err,
  output logic [CNT_W-1:0] ticks_done
`ifdef TIMER_STICKY_IRQ_EN
  ,
  input  logic             irq_clr,
  output logic             irq
`endif
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t             r_state;
  logic [LFSR_W-1:0]  r_lfsr;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   r_interval;
  logic               r_periodic;
  logic               r_tick;
  logic               r_timeout;
  logic               r_err;

  logic               w_fb;
  logic [LFSR_W-1:0]  w_lfsr_step;
  logic               w_at_end;
  logic [CNT_W-1:0]   w_count_inc;
  logic               w_hit;
  logic               w_counting;
  logic               w_tick_evt;
  logic               w_timeout_evt;
  logic               w_err_evt;

  // XNOR feedback keeps the all-zero state legal, so the sequence starts at 0.
  assign w_fb        = ~^(r_lfsr & TAPS);
  assign w_lfsr_step = {r_lfsr[LFSR_W-2:0], w_fb};
  assign w_at_end    = (r_lfsr == TICK_END);

  // Count compares against the value it is about to take, so timeout coincides with the last tick.
  assign w_count_inc = r_count + CNT_W'(1);
  assign w_hit       = (w_count_inc == r_interval);

  // abort and start both pre-empt counting on the same edge.
  assign w_counting    = (r_state == ST_RUN) && enable && !start && !abort;
  assign w_tick_evt    = w_counting && w_at_end;
  assign w_timeout_evt = w_tick_evt && w_hit;
  assign w_err_evt     = !abort && start && (interval == '0);

  // Timer FSM: abort > start > counting, with registered pulse outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_lfsr     <= '0;
      r_count    <= '0;
      r_interval <= '0;
      r_periodic <= 1'b0;
      r_tick     <= 1'b0;
      r_timeout  <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_tick    <= w_tick_evt;
      r_timeout <= w_timeout_evt;
      r_err     <= w_err_evt;
      if (abort) begin
        r_state <= ST_IDLE;
        r_lfsr  <= '0;
        r_count <= '0;
      end else if (start) begin
        // A zero interval is rejected and leaves everything untouched.
        if (interval != '0) begin
          r_interval <= interval;
          r_periodic <= periodic;
          r_lfsr     <= '0;
          r_count    <= '0;
          r_state    <= ST_RUN;
        end
      end else if (w_counting) begin
        if (w_at_end) begin
          r_lfsr <= '0;
          if (w_hit) begin
            r_count <= '0;
            if (!r_periodic) begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_count <= w_count_inc;
          end
        end else begin
          r_lfsr <= w_lfsr_step;
        end
      end
    end
  end

  assign busy       = (r_state == ST_RUN);
  assign tick       = r_tick;
  assign timeout    = r_timeout;
  assign err        = r_err;
  assign ticks_done = r_count;

`ifdef TIMER_STICKY_IRQ_EN
  logic r_irq;

  // Sticky interrupt: set by a timeout, cleared by irq_clr; a simultaneous set wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_irq <= 1'b0;
    end else if (w_timeout_evt) begin
      r_irq <= 1'b1;
    end else if (irq_clr) begin
      r_irq <= 1'b0;
    end
  end

  assign irq = r_irq;
`endif

endmodule

// File: tb/tb_lfsr_interval_timer.sv
// tb_lfsr_interval_timer: table-driven bench for lfsr_interval_timer using a
// 4-bit LFSR (0000,0001,0011,0111 -> base tick every 4 enabled cycles) and a
// 3-bit tick counter.
module tb_lfsr_interval_timer;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       start;
  logic       abort;
  logic       periodic;
  logic [2:0] interval;
  logic       busy;
  logic       tick;
  logic       timeout;
  logic       err;
  logic [2:0] ticks_done;

  int checks = 0;
  int errors = 0;

  // One record per clock edge: inputs driven before the edge, outputs expected after it.
  // exp = {busy, tick, timeout, err, ticks_done}
  typedef struct packed {
    logic [7:0] scen;
    logic       en;
    logic       st;
    logic       ab;
    logic       per;
    logic [2:0] iv;
    logic [6:0] exp;
  } vec_t;

  vec_t       vecs[$];
  logic [6:0] sb_q[$];

  lfsr_interval_timer #(
    .LFSR_W  (4),
    .TAPS    (4'b1100),
    .TICK_END(4'b0111),
    .CNT_W   (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .start     (start),
    .abort     (abort),
    .periodic  (periodic),
    .interval  (interval),
    .busy      (busy),
    .tick      (tick),
    .timeout   (timeout),
    .err       (err),
    .ticks_done(ticks_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input int sc, input logic en, input logic st, input logic ab,
                     input logic per, input logic [2:0] iv, input logic b,
                     input logic tk, input logic to, input logic er,
                     input logic [2:0] cnt);
    vec_t v;
    v.scen = 8'(sc);
    v.en   = en;
    v.st   = st;
    v.ab   = ab;
    v.per  = per;
    v.iv   = iv;
    v.exp  = {b, tk, to, er, cnt};
    vecs.push_back(v);
  endtask

  // n quiet edges: no start/abort, expected outputs steady with no pulses.
  task automatic hold(input int sc, input int n, input logic en, input logic b,
                      input logic [2:0] cnt);
    for (int i = 0; i < n; i++) begin
      add(sc, en, 1'b0, 1'b0, 1'b0, 3'd0, b, 1'b0, 1'b0, 1'b0, cnt);
    end
  endtask

  // An enabled edge on which a base tick is expected.
  task automatic tk(input int sc, input logic b, input logic to, input logic [2:0] cnt);
    add(sc, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, b, 1'b1, to, 1'b0, cnt);
  endtask

  task automatic chk(input string name, input logic [6:0] got, input logic [6:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: busy/tick/timeout/err/ticks_done got %b_%b_%b_%b_%0d want %b_%b_%b_%b_%0d",
               name, got[6], got[5], got[4], got[3], got[2:0],
               want[6], want[5], want[4], want[3], want[2:0]);
    end else begin
      $display("ok   %s: busy/tick/timeout/err/ticks_done %b_%b_%b_%b_%0d",
               name, got[6], got[5], got[4], got[3], got[2:0]);
    end
  endtask

  function automatic logic [6:0] outs();
    return {busy, tick, timeout, err, ticks_done};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- build vector table ----------------
    // 1: one-shot, interval 3
    add(1, 1, 1, 0, 0, 3'd3, 1, 0, 0, 0, 3'd0);
    hold(1, 3, 1, 1, 3'd0);
    tk(1, 1, 0, 3'd1);
    hold(1, 3, 1, 1, 3'd1);
    tk(1, 1, 0, 3'd2);
    hold(1, 3, 1, 1, 3'd2);
    tk(1, 0, 1, 3'd0);
    hold(1, 3, 1, 0, 3'd0);
    // 2: periodic, interval 2, abort at edge 26
    add(2, 1, 1, 0, 1, 3'd2, 1, 0, 0, 0, 3'd0);
    for (int r = 0; r < 3; r++) begin
      hold(2, 3, 1, 1, 3'd0);
      tk(2, 1, 0, 3'd1);
      hold(2, 3, 1, 1, 3'd1);
      tk(2, 1, 1, 3'd0);
    end
    hold(2, 1, 1, 1, 3'd0);
    add(2, 1, 0, 1, 0, 3'd0, 0, 0, 0, 0, 3'd0);
    hold(2, 6, 1, 0, 3'd0);
    // 3: pause with enable=0 on edges 5-9
    add(3, 1, 1, 0, 0, 3'd3, 1, 0, 0, 0, 3'd0);
    hold(3, 3, 1, 1, 3'd0);
    tk(3, 1, 0, 3'd1);
    hold(3, 5, 0, 1, 3'd1);
    hold(3, 3, 1, 1, 3'd1);
    tk(3, 1, 0, 3'd2);
    hold(3, 3, 1, 1, 3'd2);
    tk(3, 0, 1, 3'd0);
    hold(3, 2, 1, 0, 3'd0);
    // 4: retrigger at edge 6
    add(4, 1, 1, 0, 0, 3'd3, 1, 0, 0, 0, 3'd0);
    hold(4, 3, 1, 1, 3'd0);
    tk(4, 1, 0, 3'd1);
    hold(4, 1, 1, 1, 3'd1);
    add(4, 1, 1, 0, 0, 3'd3, 1, 0, 0, 0, 3'd0);
    hold(4, 3, 1, 1, 3'd0);
    tk(4, 1, 0, 3'd1);
    hold(4, 3, 1, 1, 3'd1);
    tk(4, 1, 0, 3'd2);
    hold(4, 3, 1, 1, 3'd2);
    tk(4, 0, 1, 3'd0);
    hold(4, 2, 1, 0, 3'd0);
    // 5: zero-interval error, start+abort priority, error while running, interval 1
    add(5, 1, 1, 0, 0, 3'd0, 0, 0, 0, 1, 3'd0);
    hold(5, 1, 1, 0, 3'd0);
    add(5, 1, 1, 1, 0, 3'd3, 0, 0, 0, 0, 3'd0);
    hold(5, 4, 1, 0, 3'd0);
    add(5, 1, 1, 0, 0, 3'd2, 1, 0, 0, 0, 3'd0);
    hold(5, 3, 1, 1, 3'd0);
    add(5, 1, 1, 0, 0, 3'd0, 1, 0, 0, 1, 3'd0);
    tk(5, 1, 0, 3'd1);
    add(5, 1, 0, 1, 0, 3'd0, 0, 0, 0, 0, 3'd0);
    add(5, 1, 1, 0, 0, 3'd1, 1, 0, 0, 0, 3'd0);
    hold(5, 3, 1, 1, 3'd0);
    tk(5, 0, 1, 3'd0);
    hold(5, 2, 1, 0, 3'd0);
    // 7: maximum interval (7), periodic, abort on the edge a tick would land
    add(7, 1, 1, 0, 1, 3'd7, 1, 0, 0, 0, 3'd0);
    for (int k = 1; k <= 7; k++) begin
      hold(7, 3, 1, 1, 3'(k - 1));
      tk(7, 1, (k == 7), (k == 7) ? 3'd0 : 3'(k));
    end
    hold(7, 3, 1, 1, 3'd0);
    add(7, 1, 0, 1, 0, 3'd0, 0, 0, 0, 0, 3'd0);
    hold(7, 1, 1, 0, 3'd0);

    // ---------------- reset ----------------
    rst      = 1'b1;
    enable   = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    periodic = 1'b0;
    interval = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", outs(), 7'b0);
    @(negedge clk);
    rst = 1'b0;

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      enable   = vecs[i].en;
      start    = vecs[i].st;
      abort    = vecs[i].ab;
      periodic = vecs[i].per;
      interval = vecs[i].iv;
      sb_q.push_back(vecs[i].exp);
      @(posedge clk);
      #1;
      chk($sformatf("s%0d.v%0d", vecs[i].scen, i), outs(), sb_q.pop_front());
    end

    // ---------------- 6: reset in the middle of a run ----------------
    @(negedge clk);
    enable   = 1'b1;
    start    = 1'b1;
    abort    = 1'b0;
    periodic = 1'b0;
    interval = 3'd3;
    @(posedge clk);
    #1;
    chk("s6.start", outs(), {1'b1, 1'b0, 1'b0, 1'b0, 3'd0});
    @(negedge clk);
    start = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      @(posedge clk);
      #1;
      chk($sformatf("s6.edge%0d", e), outs(),
          {1'b1, (e == 4), 1'b0, 1'b0, (e >= 4) ? 3'd1 : 3'd0});
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("s6.async_reset", outs(), 7'b0);
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("s6.start_in_reset", outs(), 7'b0);
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    for (int e = 0; e < 5; e++) begin
      @(posedge clk);
      #1;
      chk($sformatf("s6.idle%0d", e), outs(), 7'b0);
    end
    @(negedge clk);
    start    = 1'b1;
    interval = 3'd1;
    @(posedge clk);
    #1;
    chk("s6.restart", outs(), {1'b1, 1'b0, 1'b0, 1'b0, 3'd0});
    @(negedge clk);
    start = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk);
      #1;
      chk($sformatf("s6.run%0d", e), outs(),
          {(e != 4), (e == 4), (e == 4), 1'b0, 3'd0});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
